// File: rtl/calculator_pkg.sv
// calculator_pkg
//   Shared types and default widths for the calculator core slice.
//   - op_e    : 2-bit opcode carried on function_in (ADD, SUB, MUL, DIV)
//   - state_e : control FSM states of calculator_core
//   - DEFAULT_DATA_W / DEFAULT_OUT_W : default operand / result widths
package calculator_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_OUT_W  = 2 * DEFAULT_DATA_W;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/calculator_iter_unit.sv
// calculator_iter_unit
//   Shared one-bit-per-cycle datapath for unsigned shift-add multiply and
//   restoring divide. Both algorithms use the same register set:
//     acc  : product high half (MUL) / partial remainder (DIV)
//     sreg : multiplier being consumed (MUL) / dividend -> quotient (DIV)
//     opnd : multiplicand (MUL) / divisor (DIV)
//   so the result is {acc, sreg} in both modes.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture a/b/is_div and arm the counter at DATA_W-1
//   step     : perform one iteration
//   is_div   : 1 = divide, 0 = multiply (sampled on load)
//   a, b     : operands (a = multiplicand/dividend, b = multiplier/divisor)
//   last     : counter has reached 0; the current step is the final one
//   result   : {acc, sreg}
module calculator_iter_unit
    import calculator_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned OUT_W  = DEFAULT_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              last,
    output logic [OUT_W-1:0]  result
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] opnd;
    logic [CNT_W-1:0]  cnt;
    logic              div_mode;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W-1:0] div_diff;
    logic              div_ge;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] sreg_nxt;

    always_comb begin
        // MUL: add multiplicand into the high half when the multiplier LSB
        // is set, then shift {carry, acc, sreg} right by one.
        mul_sum   = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : '0);
        // DIV: shift the next dividend bit into the remainder and try a
        // subtract. A successful subtract always yields a value below the
        // divisor, so the low DATA_W bits of the modular difference suffice.
        div_shift = {acc, sreg[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[DATA_W-1:0] - opnd;

        if (div_mode) begin
            acc_nxt  = div_ge ? div_diff : div_shift[DATA_W-1:0];
            sreg_nxt = {sreg[DATA_W-2:0], div_ge};
        end else begin
            acc_nxt  = mul_sum[DATA_W:1];
            sreg_nxt = {mul_sum[0], sreg[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            sreg     <= '0;
            opnd     <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            sreg     <= is_div ? a : b;
            opnd     <= is_div ? b : a;
            cnt      <= CNT_W'(DATA_W - 1);
            div_mode <= is_div;
        end else if (step) begin
            acc  <= acc_nxt;
            sreg <= sreg_nxt;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign last   = (cnt == '0);
    assign result = {acc, sreg};

endmodule

// File: rtl/calculator_core.sv
// calculator_core
//   Responder end of the calculator_io interface. Captures operands and
//   opcode on a start handshake, computes ADD/SUB in one cycle and MUL/DIV
//   iteratively (one bit per cycle), and registers a result with status.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   dat_a_in        : operand A (unsigned)
//   dat_b_in        : operand B (unsigned)
//   function_in     : opcode 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   start_in        : request, accepted only in IDLE
//   busy_out        : operation in flight
//   done_out        : one-cycle pulse when out is updated
//   div_by_zero_out : pulses with done_out for DIV with B == 0
//   out             : registered result, held until the next completion
module calculator_core
    import calculator_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned OUT_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dat_a_in,
    input  logic [DATA_W-1:0] dat_b_in,
    input  logic [1:0]        function_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              div_by_zero_out,
    output logic [OUT_W-1:0]  out
);

    state_e            state;
    op_e               op_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;

    logic              accept;
    logic              iter_op;
    logic              iter_last;
    logic [OUT_W-1:0]  iter_result;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   sub_diff;
    logic [OUT_W-1:0]  result_nxt;
    logic              b_zero;

    assign accept  = start_in && (state == IDLE);
    // function_in[1] set selects the iterative MUL/DIV path.
    assign iter_op = function_in[1];
    assign b_zero  = (b_reg == '0);

    calculator_iter_unit #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && iter_op),
        .step   (state == CALC),
        .is_div (function_in[0]),
        .a      (dat_a_in),
        .b      (dat_b_in),
        .last   (iter_last),
        .result (iter_result)
    );

    always_comb begin
        add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
        sub_diff = {1'b0, a_reg} - {1'b0, b_reg};
        case (op_reg)
            OP_ADD:  result_nxt = {{(OUT_W-DATA_W-1){1'b0}}, add_sum};
            OP_SUB:  result_nxt = {{(OUT_W-DATA_W-1){sub_diff[DATA_W]}}, sub_diff};
            OP_MUL:  result_nxt = iter_result;
            OP_DIV:  result_nxt = b_zero ? '1 : iter_result;
            default: result_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            op_reg          <= OP_ADD;
            a_reg           <= '0;
            b_reg           <= '0;
            out             <= '0;
            done_out        <= 1'b0;
            div_by_zero_out <= 1'b0;
        end else begin
            done_out        <= 1'b0;
            div_by_zero_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= dat_a_in;
                        b_reg  <= dat_b_in;
                        op_reg <= op_e'(function_in);
                        state  <= iter_op ? CALC : FINISH;
                    end
                end
                CALC: begin
                    if (iter_last) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    out             <= result_nxt;
                    done_out        <= 1'b1;
                    div_by_zero_out <= (op_reg == OP_DIV) && b_zero;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational from state so an asynchronous reset clears it at once.
    assign busy_out = (state != IDLE);

endmodule

// File: doc/calculator_core.md
Name: calculator_core

Overview:
- Responder (DUT) end of the calculator_io interface.
- Samples dat_a_in, dat_b_in and function_in on a start handshake, then computes the result:
  - ADD and SUB in a single cycle.
  - MUL and DIV iteratively, one bit per cycle.
- Drives a 16-bit result with busy/done status.
- Sits behind the interface's dut modport and is extended with start_in, busy_out, done_out and div_by_zero_out.

Parameters:
- DATA_W, 8, operand width; the iteration count for MUL/DIV equals DATA_W.
- OUT_W, 2*DATA_W, result width (16 at default).

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst, input, 1, reset, asynchronous and active-high.
- dat_a_in, input, DATA_W, operand A (unsigned).
- dat_b_in, input, DATA_W, operand B (unsigned).
- function_in, input, 2, opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- start_in, input, 1, request; operands and opcode are captured when accepted.
- busy_out, output, 1, high while an operation is in flight.
- done_out, output, 1, one-cycle pulse when out is updated.
- div_by_zero_out, output, 1, pulses together with done_out for DIV with B==0.
- out, output, OUT_W, registered result; holds its value until the next completion.

Behaviour:
- Reset (rst high, asynchronous): state IDLE; out=0, busy_out=0, done_out=0, div_by_zero_out=0; iteration counter and operand registers cleared.
  - Reset during an operation aborts it; no done_out pulse is produced.
  - First accept is possible on the first rising edge after rst deasserts.
- Accept: start_in==1 at a rising edge E0 while state==IDLE. Captures A, B and op. busy_out goes high after E0.
- start_in while busy_out==1 is ignored; it is not queued.
- States:
  - IDLE: waiting for accept.
  - CALC: MUL/DIV iterating, counter runs DATA_W-1 down to 0.
  - FINISH: result is registered.
- Transitions:
  - ADD/SUB: IDLE -> FINISH at E0. Result registered at E1.
  - MUL/DIV: IDLE -> CALC at E0. Iterations run on edges E1..E8, CALC -> FINISH at E8, result registered at E9.
  - FINISH -> IDLE at the registering edge.
- Latency from accept edge to the edge that registers out and raises done_out:
  - ADD/SUB: 1 cycle.
  - MUL/DIV: DATA_W+1 cycles (9 at default).
- At the registering edge: done_out=1 for exactly one cycle; busy_out drops to 0 at the same edge.
- Back-to-back: start_in high in the cycle where done_out==1 is accepted, because state is IDLE.
- Arithmetic:
  - ADD: out = zero-extended 9-bit sum A+B.
  - SUB: out = 9-bit difference A-B, sign-extended to OUT_W (two's complement).
  - MUL: unsigned shift-add, out = A*B, full OUT_W product with no truncation.
  - DIV: restoring division, out = {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}.
  - DIV with B==0: full-length iteration still runs; out=all ones; div_by_zero_out pulses with done_out.
- Operand pins are don't-care after accept; changing them mid-operation has no effect.

Decomposition:
- calculator_pkg holds:
  - op_e enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - state_e enum: IDLE, CALC, FINISH.
  - DATA_W/OUT_W default constants.
- One sub-module, calculator_iter_unit, implements the shared iterative MUL/DIV datapath: accumulator, shift register and counter, with load/step/last controls.
- calculator_core contains the FSM, the ADD/SUB path, the output registers and the handshake.

Test Plan:
1. ADD A=8'hFF, B=8'h01, start one cycle -> out=16'h0100, done_out pulses 1 cycle after accept; busy_out high for exactly 1 cycle.
2. SUB A=8'h03, B=8'h05 -> out=16'hFFFE; SUB A=8'h05, B=8'h03 -> out=16'h0002.
3. MUL A=8'hFF, B=8'hFF -> out=16'hFE01, done_out exactly 9 cycles after the accept edge, busy_out high for 9 cycles. Change dat_a_in mid-operation: result unchanged.
4. DIV A=200, B=7 -> out=16'h041C (rem 4, quot 28). DIV A=10, B=0 -> out=16'hFFFF with div_by_zero_out and done_out both pulsing after 9 cycles.
5. Hold start_in high during a MUL: the only second accept is in the done_out cycle, so the second op (ADD 1+1) yields out=16'h0002 one cycle later.
6. Assert rst 4 cycles into a MUL -> out/busy_out/done_out go to 0 immediately, without waiting for a clock edge, and no done_out pulse follows. After release, ADD 2+3 -> out=16'h0005.
